// File: rtl/acumulador_ula.sv
// Control and result stage around the 8-bit ULA: accumulator, command/result handshakes, sticky overflow.
// Optional macro ACUMULADOR_CONTA_OVF_EN adds the saturating ovf_contagem counter output.
module acumulador_ula #(
   parameter int BITS = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [BITS-1:0] cmd_operando,
   input  logic            cmd_carrega,
   output logic [BITS-1:0] ula_A,
   output logic [BITS-1:0] ula_B,
   output logic [1:0]      ula_F,
   input  logic [BITS-1:0] ula_Saida,
   input  logic            ula_FLAG_O,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [BITS-1:0] res_dado,
   output logic            res_ovf,
   output logic            ovf_sticky,
`ifdef ACUMULADOR_CONTA_OVF_EN
   output logic [7:0]      ovf_contagem,
`endif
   input  logic            limpa_ovf
);

   typedef enum logic [1:0] {OCIOSO, EXECUTA, RESULTADO} estado_t;

   estado_t         estado_q, estado_d;
   logic [BITS-1:0] acc_q, acc_d;
   logic [BITS-1:0] opnd_q, opnd_d;
   logic [1:0]      op_q, op_d;
   logic            res_ovf_q, res_ovf_d;
   logic            sticky_q, sticky_d;
   logic            captura_ovf;

   assign captura_ovf = (estado_q == EXECUTA) && ula_FLAG_O;

   always_comb begin
      estado_d  = estado_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      res_ovf_d = res_ovf_q;
      case (estado_q)
         OCIOSO: begin
            if (cmd_valid) begin
               if (cmd_carrega) begin
                  acc_d     = cmd_operando;
                  res_ovf_d = 1'b0;
                  estado_d  = RESULTADO;
               end else begin
                  opnd_d   = cmd_operando;
                  op_d     = cmd_op;
                  estado_d = EXECUTA;
               end
            end
         end
         EXECUTA: begin
            acc_d     = ula_Saida;
            res_ovf_d = ula_FLAG_O;
            estado_d  = RESULTADO;
         end
         RESULTADO: begin
            if (res_ready) estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // A coinciding capture overrides the clear.
   always_comb begin
      sticky_d = sticky_q;
      if (limpa_ovf)   sticky_d = 1'b0;
      if (captura_ovf) sticky_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q  <= OCIOSO;
         acc_q     <= '0;
         opnd_q    <= '0;
         op_q      <= 2'd0;
         res_ovf_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         res_ovf_q <= res_ovf_d;
         sticky_q  <= sticky_d;
      end
   end

`ifdef ACUMULADOR_CONTA_OVF_EN
   logic [7:0] cont_q, cont_d;

   always_comb begin
      cont_d = cont_q;
      if (captura_ovf) begin
         if (limpa_ovf)             cont_d = 8'd1;
         else if (cont_q != 8'hFF)  cont_d = cont_q + 8'd1;
      end else if (limpa_ovf) begin
         cont_d = 8'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cont_q <= 8'd0;
      else          cont_q <= cont_d;
   end

   assign ovf_contagem = cont_q;
`endif

   assign cmd_ready  = (estado_q == OCIOSO);
   assign res_valid  = (estado_q == RESULTADO);
   assign res_dado   = acc_q;
   assign res_ovf    = res_ovf_q;
   assign ovf_sticky = sticky_q;
   assign ula_A      = acc_q;
   assign ula_B      = opnd_q;
   assign ula_F      = op_q;

endmodule

// File: tb/tb_acumulador_ula.sv
// Randomized bench for acumulador_ula with a behavioural ULA and a transaction-level reference model.
module tb_acumulador_ula;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_operando = 8'd0;
   logic       cmd_carrega = 1'b0;
   logic [7:0] ula_A, ula_B, ula_Saida;
   logic [1:0] ula_F;
   logic       ula_FLAG_O;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_dado;
   logic       res_ovf;
   logic       ovf_sticky;
   logic       limpa_ovf = 1'b0;
`ifdef ACUMULADOR_CONTA_OVF_EN
   logic [7:0] ovf_contagem;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_acc = 0, m_ovf = 0, m_sticky = 0, m_cnt = 0;

   acumulador_ula #(.BITS(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_operando(cmd_operando), .cmd_carrega(cmd_carrega),
      .ula_A(ula_A), .ula_B(ula_B), .ula_F(ula_F),
      .ula_Saida(ula_Saida), .ula_FLAG_O(ula_FLAG_O),
      .res_valid(res_valid), .res_ready(res_ready), .res_dado(res_dado),
      .res_ovf(res_ovf), .ovf_sticky(ovf_sticky),
`ifdef ACUMULADOR_CONTA_OVF_EN
      .ovf_contagem(ovf_contagem),
`endif
      .limpa_ovf(limpa_ovf)
   );

   always #5 clock = ~clock;

   // behavioural ULA
   always_comb begin
      logic [7:0] t;
      t = 8'd0;
      ula_FLAG_O = 1'b0;
      case (ula_F)
         2'd0: t = ula_A & ula_B;
         2'd1: t = ula_A | ula_B;
         2'd2: begin
            t = ula_A + ula_B;
            ula_FLAG_O = (ula_A[7] == ula_B[7]) && (t[7] != ula_A[7]);
         end
         default: begin
            t = ula_A - ula_B;
            ula_FLAG_O = (ula_A[7] != ula_B[7]) && (t[7] != ula_A[7]);
         end
      endcase
      ula_Saida = t;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   task automatic ref_op(input int op, input int a, input int b, output int r, output int ov);
      int s;
      ov = 0;
      case (op)
         0: r = a & b;
         1: r = a | b;
         2: begin s = sgn(a) + sgn(b); r = (a + b) % 256; ov = (s > 127 || s < -128); end
         default: begin s = sgn(a) - sgn(b); r = (a - b + 256) % 256; ov = (s > 127 || s < -128); end
      endcase
   endtask

   task automatic check_result(input string tag);
      check({tag, ".res_valid"}, res_valid, 1);
      check({tag, ".cmd_ready"}, cmd_ready, 0);
      check({tag, ".res_dado"}, res_dado, m_acc);
      check({tag, ".res_ovf"}, res_ovf, m_ovf);
      check({tag, ".sticky"}, ovf_sticky, m_sticky);
`ifdef ACUMULADOR_CONTA_OVF_EN
      check({tag, ".contagem"}, ovf_contagem, m_cnt);
`endif
   endtask

   task automatic do_cmd(input int carrega, input int op, input int val, input int hold, input int limpa);
      int r, ov;
      @(negedge clock);
      check("idle.cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_carrega = carrega[0]; cmd_op = op[1:0]; cmd_operando = val[7:0];
      @(negedge clock);
      // keep presenting a conflicting command; it must be ignored
      cmd_carrega = 1'b1; cmd_operando = ~val[7:0]; cmd_op = ~op[1:0];
      if (carrega != 0) begin
         m_acc = val; m_ovf = 0;
      end else begin
         check("exec.res_valid", res_valid, 0);
         check("exec.cmd_ready", cmd_ready, 0);
         check("exec.ula_A", ula_A, m_acc);
         check("exec.ula_B", ula_B, val);
         check("exec.ula_F", ula_F, op);
         limpa_ovf = limpa[0];
         ref_op(op, m_acc, val, r, ov);
         m_acc = r; m_ovf = ov;
         if (limpa != 0) begin m_sticky = 0; m_cnt = 0; end
         if (ov != 0) begin
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
         end
         @(negedge clock);
         limpa_ovf = 1'b0;
      end
      check_result("res");
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check_result("hold");
      end
      res_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clock);
      res_ready = 1'b0;
      check("done.res_valid", res_valid, 0);
      check("done.res_dado", res_dado, m_acc);
      $display("txn carrega=%0d op=%0d val=0x%02h hold=%0d limpa=%0d -> acc=0x%02h ovf=%0d sticky=%0d",
               carrega, op, val, hold, limpa, m_acc, m_ovf, m_sticky);
   endtask

   task automatic reset_model();
      m_acc = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0;
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1;
      check("rst.cmd_ready", cmd_ready, 1);
      check("rst.res_valid", res_valid, 0);
      check("rst.res_dado", res_dado, 0);
      check("rst.res_ovf", res_ovf, 0);
      check("rst.sticky", ovf_sticky, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      do_cmd(1, 0, 8'h40, 0, 0);
      do_cmd(0, 2, 8'h40, 0, 0);   // 0x80, overflow
      do_cmd(0, 3, 8'h01, 0, 0);   // 0x7F, overflow
      do_cmd(0, 0, 8'h0F, 5, 0);   // 0x0F, sticky stays, held 5 cycles
      do_cmd(1, 0, 8'h7F, 0, 0);
      do_cmd(0, 2, 8'h01, 0, 1);   // clear coincides with capture
      @(negedge clock);
      limpa_ovf = 1'b1;
      @(negedge clock);
      limpa_ovf = 1'b0;
      m_sticky = 0; m_cnt = 0;
      check("limpa.sticky", ovf_sticky, 0);
`ifdef ACUMULADOR_CONTA_OVF_EN
      check("limpa.contagem", ovf_contagem, 0);
`endif

      for (int n = 0; n < 60; n++) begin
         do_cmd(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? 1 : 0);
      end

      // reset dropped while in EXECUTA
      @(negedge clock);
      cmd_valid = 1'b1; cmd_carrega = 1'b0; cmd_op = 2'd2; cmd_operando = 8'h7F;
      @(negedge clock);
      cmd_valid = 1'b0;
      check("rstx.in_exec", cmd_ready, 0);
      reset_n = 1'b0;
      #1;
      reset_model();
      check("rstx.res_valid", res_valid, 0);
      check("rstx.res_dado", res_dado, 0);
      check("rstx.res_ovf", res_ovf, 0);
      check("rstx.sticky", ovf_sticky, 0);
      check("rstx.cmd_ready", cmd_ready, 1);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("rstx.no_stale", res_valid, 0);
         check("rstx.acc", res_dado, 0);
      end
      do_cmd(0, 1, 8'h5A, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acumulador_ula.md
Name: acumulador_ula

Overview:
- Sequential control and result stage wrapped around the combinational 8-bit ULA (AND/OR/ADD/SUB with overflow flag).
- Accepts commands over a valid/ready handshake and drives the ULA operand and opcode inputs, with the accumulator as A and the command operand as B.
- Captures the ULA result and overflow flag into the accumulator and presents them downstream over a second valid/ready handshake.
- Keeps a sticky overflow indicator.

Parameters:
BITS, 8, datapath width; must match the ULA instance.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  ULA opcode: 0 AND, 1 OR, 2 ADD, 3 SUB
cmd_operando  input  BITS  operand B, or load value
cmd_carrega  input  1  1 = load cmd_operando into accumulator, no ULA operation
ula_A  output  BITS  to ULA A (accumulator)
ula_B  output  BITS  to ULA B (registered operand)
ula_F  output  2  to ULA F (registered opcode)
ula_Saida  input  BITS  from ULA result
ula_FLAG_O  input  1  from ULA overflow flag
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_dado  output  BITS  accumulator value
res_ovf  output  1  overflow flag of the last operation
ovf_sticky  output  1  set by any captured overflow
limpa_ovf  input  1  synchronous clear of ovf_sticky

Behaviour:
- FSM states: OCIOSO, EXECUTA, RESULTADO. Reset state is OCIOSO.
- Reset (async, reset_n=0):
  - state OCIOSO; accumulator, operand reg, opcode reg all 0.
  - res_ovf=0, ovf_sticky=0, res_valid=0.
  - cmd_ready=1, since it is decoded from state.
- cmd_ready = (state==OCIOSO). res_valid = (state==RESULTADO). res_dado = accumulator at all times.
- OCIOSO, cmd_valid=1 (handshake at that edge):
  - cmd_carrega=1: accumulator <= cmd_operando; res_ovf <= 0; next state RESULTADO. Latency 1 cycle.
  - cmd_carrega=0: operand reg <= cmd_operando; opcode reg <= cmd_op; next state EXECUTA.
- EXECUTA (exactly 1 cycle):
  - ULA inputs are stable for this cycle: ula_A=accumulator, ula_B=operand reg, ula_F=opcode reg.
  - At the clock edge: accumulator <= ula_Saida; res_ovf <= ula_FLAG_O; ovf_sticky |= ula_FLAG_O.
  - Next state RESULTADO. Accept-to-res_valid latency is 2 cycles.
- RESULTADO:
  - Hold res_valid, res_dado and res_ovf stable until res_ready=1.
  - On the res_ready=1 edge, go to OCIOSO.
  - Throughput is one command per 3 cycles minimum.
- cmd_valid is ignored outside OCIOSO (cmd_ready=0). The upstream side must hold the command.
- Arithmetic wraps modulo 2^BITS. Overflow detection belongs to the ULA; this block only registers the flag. For opcodes 0 and 1 the flag captured is whatever the ULA drives (0).
- ula_A, ula_B and ula_F are driven directly from registers in every state, with no glitching. They are only meaningful in EXECUTA.
- ovf_sticky:
  - limpa_ovf=1 clears it at the edge.
  - If a clear and an overflow capture coincide, the set wins (result 1).
  - limpa_ovf has no other effect.
- Reset asserted mid-operation (EXECUTA or RESULTADO): the command and result are dropped and all registers take their reset values immediately. No result is delivered.

Optional Feature:
- Macro: ACUMULADOR_CONTA_OVF_EN.
- Defined:
  - Adds output ovf_contagem [7:0]: counts EXECUTA cycles in which ula_FLAG_O=1, saturating at 255.
  - Reset value 0. limpa_ovf zeroes it.
  - If limpa_ovf coincides with a captured overflow, the result is 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Release reset; cmd carrega=1, operando=0x40 -> res_valid 1 cycle after accept; res_dado=0x40, res_ovf=0, cmd_ready=0 until res_ready.
- acc=0x40; cmd op=2, operando=0x40 -> during EXECUTA ula_A=0x40, ula_B=0x40, ula_F=2; res_valid 2 cycles after accept; res_dado=0x80, res_ovf=1, ovf_sticky=1.
- acc=0x80; op=3, operando=0x01 -> res_dado=0x7F, res_ovf=1. Then op=0, operando=0x0F -> res_dado=0x0F, res_ovf=0, ovf_sticky stays 1.
- res_ready=0 for 5 cycles while in RESULTADO, with cmd_valid=1 and a different command presented -> res_valid=1 and res_dado held; cmd_ready=0; command not taken; accumulator unchanged.
- limpa_ovf=1 on the same edge as an ADD 0x7F+0x01 capture -> ovf_sticky=1. limpa_ovf=1 alone next cycle -> ovf_sticky=0.
- Drop reset_n in EXECUTA -> in the same cycle: res_valid=0, res_dado=0, res_ovf=0, ovf_sticky=0, cmd_ready=1. After release, no stale result appears.
